// File: rtl/mem_bus_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// Responses return in issue order. A small ID FIFO routes each response to its requester.
module mem_bus_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          instr_err_o,
   input  logic          data_req_i,
   input  logic          data_we_i,
   input  logic [3:0]    data_be_i,
   input  logic [31:0]   data_addr_i,
   input  logic [31:0]   data_wdata_i,
   output logic          data_gnt_o,
   output logic          data_rvalid_o,
   output logic [31:0]   data_rdata_o,
   output logic          data_err_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [31:0]   mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [31:0]   mem_rdata_i,
   input  logic          mem_err_i,
   output logic          dbg_state,
   output logic [CW-1:0] dbg_count
);

   // Handshake: a request transfers in the cycle where mem_req_o and mem_gnt_i
   // are both high; once presented, a request stays selected until that cycle.
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

   typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

   state_t        state_q, state_d;
   logic          held_id_q;
   logic          last_grant_q;
   logic          id_fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic sel_valid, sel_id;
   logic hs, pop, head_id;

   // ID 0 is fetch, ID 1 is LSU.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = 1'b0;
      if (state_q == HOLD) begin
         sel_valid = 1'b1;
         sel_id    = held_id_q;
      end else if (instr_req_i && data_req_i) begin
         sel_valid = 1'b1;
         sel_id    = ~last_grant_q;
      end else if (data_req_i) begin
         sel_valid = 1'b1;
         sel_id    = 1'b1;
      end else if (instr_req_i) begin
         sel_valid = 1'b1;
         sel_id    = 1'b0;
      end
   end

   assign mem_req_o   = sel_valid && (count_q < MAX_CNT);
   assign hs          = mem_req_o && mem_gnt_i;
   assign instr_gnt_o = hs && !sel_id;
   assign data_gnt_o  = hs && sel_id;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (sel_valid) begin
         if (sel_id) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   // Responses with nothing outstanding are dropped.
   assign pop     = mem_rvalid_i && (count_q != '0);
   assign head_id = id_fifo_q[rd_ptr_q];

   assign instr_rvalid_o = pop && !head_id;
   assign data_rvalid_o  = pop && head_id;
   assign instr_err_o    = pop && !head_id && mem_err_i;
   assign data_err_o     = pop && head_id && mem_err_i;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (mem_req_o && !mem_gnt_i) state_d = HOLD;
         HOLD:    if (hs) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ARB;
         held_id_q    <= 1'b0;
         last_grant_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARB && state_d == HOLD) held_id_q <= sel_id;
         if (hs) begin
            last_grant_q <= sel_id;
            wr_ptr_q     <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         case ({hs, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; the pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (!RST && hs) id_fifo_q[wr_ptr_q] <= sel_id;
   end

   assign dbg_state = (state_q == HOLD);
   assign dbg_count = count_q;

endmodule
